// File: rtl/rob_order_queue_pkg.sv
// rob_order_queue shared definitions.
// Slot shift codes used between the queue control and its slots.
package rob_order_queue_pkg;

  typedef enum logic [1:0] {
    SHFT_IDLE = 2'd0,
    SHFT_FWD  = 2'd1,
    SHFT_REV  = 2'd2
  } shft_e;

  localparam int unsigned SHFT_W = 2;

endpackage

// File: rtl/rob_order_slot.sv
// rob_order_queue storage slot.
// Holds one {ptr, data} entry; loads, shifts fwd/rev, or holds.
module rob_order_slot
  import rob_order_queue_pkg::*;
#(
  parameter int p_bitwidth = 37
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_data,
  input  logic [p_bitwidth-1:0] wr_data_in,
  input  logic [SHFT_W-1:0]     shift_en,
  input  logic [p_bitwidth-1:0] fwd_in,
  input  logic [p_bitwidth-1:0] rev_in,
  output logic [p_bitwidth-1:0] data_out
);

  logic [p_bitwidth-1:0] data_q;

  // Write wins over shift; otherwise move from a neighbour or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (wr_data) begin
      data_q <= wr_data_in;
    end else begin
      case (shift_en)
        SHFT_FWD: data_q <= fwd_in;
        SHFT_REV: data_q <= rev_in;
        default:  data_q <= data_q;
      endcase
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/rob_order_queue.sv
// rob_order_queue: reorder stage for the v3 ROB path.
// Sorted shift array, oldest-first; releases strictly in ptr order.
module rob_order_queue
  import rob_order_queue_pkg::*;
#(
  parameter int p_depth     = 4,
  parameter int p_ptrwidth  = 5,
  parameter int p_chanwidth = 32,
  parameter int p_bitwidth  = p_ptrwidth + p_chanwidth
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enq_val,
  output logic                         enq_rdy,
  input  logic [p_bitwidth-1:0]        enq_msg,
  output logic                         deq_val,
  input  logic                         deq_rdy,
  output logic [p_chanwidth-1:0]       deq_msg,
  output logic [p_ptrwidth-1:0]        head_ptr,
  output logic [$clog2(p_depth+1)-1:0] count
);

  localparam int CW = $clog2(p_depth + 1);

  logic [CW-1:0]         cnt_q;
  logic [p_ptrwidth-1:0] head_q;

  logic [p_bitwidth-1:0] slot_q   [p_depth];
  logic [p_ptrwidth-1:0] slot_ptr [p_depth];
  logic [p_ptrwidth-1:0] slot_age [p_depth];
  logic [SHFT_W-1:0]     shf      [p_depth];
  logic [p_depth-1:0]    wr_en;
  logic [p_depth-1:0]    older;

  logic [p_ptrwidth-1:0] enq_ptr;
  logic [p_ptrwidth-1:0] enq_age;
  logic [CW-1:0]         k;
  logic                  enq_fire;
  logic                  deq_fire;
  logic                  dup;

  assign enq_ptr  = enq_msg[p_bitwidth-1 -: p_ptrwidth];
  assign enq_age  = enq_ptr - head_q;

  assign enq_rdy  = (cnt_q < CW'(p_depth));
  assign deq_val  = (cnt_q != '0) && (slot_ptr[0] == head_q);
  assign deq_msg  = slot_q[0][p_chanwidth-1:0];
  assign head_ptr = head_q;
  assign count    = cnt_q;

  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  // Age of each slot relative to head, and which occupied slots are older.
  always_comb begin
    dup = 1'b0;
    for (int j = 0; j < p_depth; j++) begin
      slot_ptr[j] = slot_q[j][p_bitwidth-1 -: p_ptrwidth];
      slot_age[j] = slot_ptr[j] - head_q;
      older[j]    = (CW'(j) < cnt_q) && (slot_age[j] < enq_age);
      if ((CW'(j) < cnt_q) && (slot_ptr[j] == enq_ptr))
        dup = 1'b1;
    end
  end

  // Insert index: count of occupied slots older than the incoming entry.
  always_comb begin
    k = '0;
    for (int j = 0; j < p_depth; j++)
      k = k + CW'(older[j]);
  end

  // Per-slot write/shift decode from the pre-update state.
  always_comb begin
    for (int j = 0; j < p_depth; j++) begin
      wr_en[j] = 1'b0;
      shf[j]   = SHFT_IDLE;
      unique case (1'b1)
        (enq_fire && !deq_fire): begin
          if (CW'(j) == k)
            wr_en[j] = 1'b1;
          else if ((CW'(j) > k) && (CW'(j) <= cnt_q))
            shf[j] = SHFT_REV;
        end
        (!enq_fire && deq_fire): begin
          if (CW'(j + 1) < cnt_q)
            shf[j] = SHFT_FWD;
        end
        (enq_fire && deq_fire): begin
          if (CW'(j + 1) == k)
            wr_en[j] = 1'b1;
          else if (CW'(j + 1) < k)
            shf[j] = SHFT_FWD;
        end
        default: ;
      endcase
    end
  end

  // Occupancy and in-order head pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (enq_fire && !deq_fire)
        cnt_q <= cnt_q + 1'b1;
      else if (!enq_fire && deq_fire)
        cnt_q <= cnt_q - 1'b1;
      if (deq_fire)
        head_q <= head_q + 1'b1;
    end
  end

  for (genvar j = 0; j < p_depth; j++) begin : g_slot
    logic [p_bitwidth-1:0] fwd_in;
    logic [p_bitwidth-1:0] rev_in;

    if (j == p_depth - 1) begin : g_last
      assign fwd_in = '0;
    end else begin : g_nxt
      assign fwd_in = slot_q[j+1];
    end

    if (j == 0) begin : g_first
      assign rev_in = '0;
    end else begin : g_prv
      assign rev_in = slot_q[j-1];
    end

    rob_order_slot #(
      .p_bitwidth(p_bitwidth)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_data   (wr_en[j]),
      .wr_data_in(enq_msg),
      .shift_en  (shf[j]),
      .fwd_in    (fwd_in),
      .rev_in    (rev_in),
      .data_out  (slot_q[j])
    );
  end

  a_no_dup: assert property (
    @(posedge clk) disable iff (!rst_n)
    enq_fire |-> !dup
  );

  a_no_head_clash: assert property (
    @(posedge clk) disable iff (!rst_n)
    enq_fire |-> !(deq_val && (enq_age == '0))
  );

  a_cnt_max: assert property (
    @(posedge clk) disable iff (!rst_n)
    cnt_q <= CW'(p_depth)
  );

  a_cnt_min: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(deq_fire && (cnt_q == '0))
  );

endmodule

// File: tb/tb_rob_order_queue.sv
// Self-checking bench for rob_order_queue.
// Directed scenarios plus random traffic against a set-based model.
module tb_rob_order_queue;

  localparam int D   = 4;
  localparam int PW  = 3;
  localparam int CHW = 8;
  localparam int BW  = PW + CHW;
  localparam int NP  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enq_val = 1'b0;
  logic           enq_rdy;
  logic [BW-1:0]  enq_msg = '0;
  logic           deq_val;
  logic           deq_rdy = 1'b0;
  logic [CHW-1:0] deq_msg;
  logic [PW-1:0]  head_ptr;
  logic [2:0]     count;

  int vec = 0;
  int errs = 0;

  int m_head = 0;
  int m_ptr[$];
  int m_dat[$];

  rob_order_queue #(
    .p_depth(D), .p_ptrwidth(PW), .p_chanwidth(CHW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_msg(enq_msg),
    .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_msg(deq_msg),
    .head_ptr(head_ptr), .count(count)
  );

  always #5 clk = ~clk;

  function automatic int m_find(input int p);
    for (int i = 0; i < m_ptr.size(); i++)
      if (m_ptr[i] == p) return i;
    return -1;
  endfunction

  function automatic void m_clear();
    m_ptr.delete();
    m_dat.delete();
    m_head = 0;
  endfunction

  task automatic tick(input bit ev, input int p, input int d,
                      input bit dr);
    logic [PW-1:0]  pp;
    logic [CHW-1:0] dd;
    bit ef, df;
    int idx;
    pp = p[PW-1:0];
    dd = d[CHW-1:0];
    enq_val = ev;
    enq_msg = {pp, dd};
    deq_rdy = dr;
    @(posedge clk);
    ef  = ev && (m_ptr.size() < D);
    idx = m_find(m_head);
    df  = dr && (idx >= 0);
    if (df) begin
      m_ptr.delete(idx);
      m_dat.delete(idx);
      m_head = (m_head + 1) % NP;
    end
    if (ef) begin
      m_ptr.push_back(p % NP);
      m_dat.push_back(d % 256);
    end
    #1;
    enq_val = 1'b0;
    deq_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if (count !== 3'd0) begin errs++; $display("FAIL rst_count got %0d want 0", count); end
    vec++; if (head_ptr !== 3'd0) begin errs++; $display("FAIL rst_head got %0d want 0", head_ptr); end
    vec++; if (deq_val !== 1'b0) begin errs++; $display("FAIL rst_deq_val got %0b want 0", deq_val); end
    vec++; if (deq_msg !== 8'h00) begin errs++; $display("FAIL rst_deq_msg got %0h want 0", deq_msg); end
    vec++; if (enq_rdy !== 1'b1) begin errs++; $display("FAIL rst_enq_rdy got %0b want 1", enq_rdy); end
  endtask

  task automatic test_in_order();
    tick(1, 0, 'hA0, 1);
    vec++; if (deq_val !== 1'b1) begin errs++; $display("FAIL io_val0 got %0b want 1", deq_val); end
    vec++; if (deq_msg !== 8'hA0) begin errs++; $display("FAIL io_msg0 got %0h want a0", deq_msg); end
    tick(1, 1, 'hA1, 1);
    vec++; if (deq_msg !== 8'hA1) begin errs++; $display("FAIL io_msg1 got %0h want a1", deq_msg); end
    vec++; if (head_ptr !== 3'd1) begin errs++; $display("FAIL io_head1 got %0d want 1", head_ptr); end
    tick(0, 0, 0, 1);
    vec++; if (head_ptr !== 3'd2) begin errs++; $display("FAIL io_head2 got %0d want 2", head_ptr); end
    vec++; if (count !== 3'd0) begin errs++; $display("FAIL io_count got %0d want 0", count); end
  endtask

  task automatic test_out_of_order();
    int h;
    logic [7:0] w;
    h = m_head;
    tick(1, h + 2, 'hC2, 0);
    tick(1, h + 0, 'hC0, 0);
    tick(1, h + 3, 'hC3, 0);
    tick(1, h + 1, 'hC1, 0);
    vec++; if (count !== 3'd4) begin errs++; $display("FAIL ooo_count got %0d want 4", count); end
    vec++; if (enq_rdy !== 1'b0) begin errs++; $display("FAIL ooo_enq_rdy got %0b want 0", enq_rdy); end
    for (int i = 0; i < 4; i++) begin
      w = 8'hC0 + 8'(i);
      vec++; if (deq_val !== 1'b1 || deq_msg !== w) begin
        errs++; $display("FAIL ooo_deq%0d got %0b/%0h want 1/%0h", i, deq_val, deq_msg, w);
      end
      tick(0, 0, 0, 1);
    end
    vec++; if (count !== 3'd0) begin errs++; $display("FAIL ooo_drain got %0d want 0", count); end
  endtask

  task automatic test_head_missing();
    int h;
    logic [7:0] w;
    h = m_head;
    tick(1, h + 1, 'h31, 0);
    tick(1, h + 2, 'h32, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 1);
      vec++; if (deq_val !== 1'b0) begin errs++; $display("FAIL hm_wait%0d got %0b want 0", i, deq_val); end
    end
    tick(1, h, 'h30, 1);
    for (int i = 0; i < 3; i++) begin
      w = 8'h30 + 8'(i);
      vec++; if (deq_val !== 1'b1 || deq_msg !== w) begin
        errs++; $display("FAIL hm_deq%0d got %0b/%0h want 1/%0h", i, deq_val, deq_msg, w);
      end
      tick(0, 0, 0, 1);
    end
  endtask

  task automatic test_simul();
    int h;
    logic [2:0] hn;
    h = m_head;
    hn = 3'((h + 1) % NP);
    tick(1, h, 'h40, 0);
    tick(1, h + 2, 'h42, 0);
    tick(1, h + 1, 'h41, 1);
    vec++; if (count !== 3'd2) begin errs++; $display("FAIL sim_count got %0d want 2", count); end
    vec++; if (head_ptr !== hn) begin errs++; $display("FAIL sim_head got %0d want %0d", head_ptr, hn); end
    vec++; if (deq_val !== 1'b1 || deq_msg !== 8'h41) begin
      errs++; $display("FAIL sim_head_msg got %0b/%0h want 1/41", deq_val, deq_msg);
    end
    tick(0, 0, 0, 1);
    vec++; if (deq_msg !== 8'h42) begin errs++; $display("FAIL sim_next got %0h want 42", deq_msg); end
    tick(0, 0, 0, 1);
    vec++; if (count !== 3'd0) begin errs++; $display("FAIL sim_drain got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    logic [7:0] wm [4];
    logic [2:0] wh [4];
    wm[0] = 8'h56; wm[1] = 8'h57; wm[2] = 8'h50; wm[3] = 8'h51;
    wh[0] = 3'd7;  wh[1] = 3'd0;  wh[2] = 3'd1;  wh[3] = 3'd2;
    for (int i = 0; i < NP && m_head != 6; i++) begin
      tick(1, m_head, 0, 0);
      tick(0, 0, 0, 1);
    end
    vec++; if (head_ptr !== 3'd6) begin errs++; $display("FAIL wr_head6 got %0d want 6", head_ptr); end
    tick(1, 1, 'h51, 0);
    tick(1, 7, 'h57, 0);
    tick(1, 0, 'h50, 0);
    tick(1, 6, 'h56, 0);
    for (int i = 0; i < 4; i++) begin
      vec++; if (deq_val !== 1'b1 || deq_msg !== wm[i]) begin
        errs++; $display("FAIL wr_deq%0d got %0b/%0h want 1/%0h", i, deq_val, deq_msg, wm[i]);
      end
      tick(0, 0, 0, 1);
      vec++; if (head_ptr !== wh[i]) begin
        errs++; $display("FAIL wr_head%0d got %0d want %0d", i, head_ptr, wh[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int h;
    h = m_head;
    tick(1, h + 1, 'h11, 0);
    tick(1, h + 2, 'h12, 0);
    tick(1, h + 3, 'h13, 0);
    vec++; if (count !== 3'd3) begin errs++; $display("FAIL ar_pre got %0d want 3", count); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_clear();
    #1;
    vec++; if (count !== 3'd0) begin errs++; $display("FAIL ar_count got %0d want 0", count); end
    vec++; if (deq_val !== 1'b0) begin errs++; $display("FAIL ar_deq_val got %0b want 0", deq_val); end
    vec++; if (enq_rdy !== 1'b1) begin errs++; $display("FAIL ar_enq_rdy got %0b want 1", enq_rdy); end
    vec++; if (head_ptr !== 3'd0) begin errs++; $display("FAIL ar_head got %0d want 0", head_ptr); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 0, 'h60, 1);
    vec++; if (deq_val !== 1'b1 || deq_msg !== 8'h60) begin
      errs++; $display("FAIL ar_post got %0b/%0h want 1/60", deq_val, deq_msg);
    end
    tick(0, 0, 0, 1);
    vec++; if (count !== 3'd0 || head_ptr !== 3'd1) begin
      errs++; $display("FAIL ar_drain got %0d/%0d want 0/1", count, head_ptr);
    end
  endtask

  task automatic test_random();
    int idx, nf, p, d;
    int free_p[$];
    bit ev, dr, mv;
    logic [7:0] wm;
    for (int c = 0; c < 600; c++) begin
      idx = m_find(m_head);
      mv  = (idx >= 0);
      vec++; if (count !== 3'(m_ptr.size())) begin
        errs++; $display("FAIL rnd_count c%0d got %0d want %0d", c, count, m_ptr.size());
      end
      vec++; if (head_ptr !== 3'(m_head)) begin
        errs++; $display("FAIL rnd_head c%0d got %0d want %0d", c, head_ptr, m_head);
      end
      vec++; if (enq_rdy !== (m_ptr.size() < D)) begin
        errs++; $display("FAIL rnd_enq_rdy c%0d got %0b want %0b", c, enq_rdy, m_ptr.size() < D);
      end
      vec++; if (deq_val !== mv) begin
        errs++; $display("FAIL rnd_deq_val c%0d got %0b want %0b", c, deq_val, mv);
      end
      if (mv) begin
        wm = 8'(m_dat[idx]);
        vec++; if (deq_msg !== wm) begin
          errs++; $display("FAIL rnd_deq_msg c%0d got %0h want %0h", c, deq_msg, wm);
        end
      end
      free_p.delete();
      for (int o = 0; o < D; o++)
        if (m_find((m_head + o) % NP) < 0)
          free_p.push_back((m_head + o) % NP);
      nf = free_p.size();
      ev = (nf > 0) && ($urandom_range(0, 2) != 0);
      p  = (nf > 0) ? free_p[$urandom_range(0, nf - 1)] : 0;
      d  = int'($urandom_range(0, 255));
      dr = ($urandom_range(0, 3) != 0);
      tick(ev, p, d, dr);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_head_missing();
    test_simul();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
